// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one calculator ALU among NumRequesters
// requesters. One transaction at a time: accept a winner's operands, issue
// them to the ALU, collect the result and hand it back to that requester.
//
// Ports
//   clk_i, rst_i                     clock, synchronous active-high reset
//   req_left_i/right_i/op_i          per-requester operands and op
//   req_in_valid_i / req_in_ready_o  per-requester operand handshake
//   req_result_o                     captured result, shared by all requesters
//   req_out_valid_o / req_out_ready_i per-requester result handshake
//   alu_left_o/right_o/op_o          registered operands to the ALU
//   alu_in_valid_o / alu_in_ready_i  ALU operand handshake
//   alu_result_i, alu_out_valid_i, alu_out_ready_o  ALU result handshake
//   grant_o                          current / last granted requester
//   busy_o                           transaction in flight

package calc_pkg;
    typedef logic [15:0] num_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;
endpackage

module alu_arbiter #(
    parameter int NumRequesters = 2,
    localparam int GW = $clog2(NumRequesters)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  calc_pkg::num_t [NumRequesters-1:0]     req_left_i,
    input  calc_pkg::num_t [NumRequesters-1:0]     req_right_i,
    input  calc_pkg::op_t  [NumRequesters-1:0]     req_op_i,
    input  logic           [NumRequesters-1:0]     req_in_valid_i,
    output logic           [NumRequesters-1:0]     req_in_ready_o,
    output calc_pkg::num_t                         req_result_o,
    output logic           [NumRequesters-1:0]     req_out_valid_o,
    input  logic           [NumRequesters-1:0]     req_out_ready_i,
    output calc_pkg::num_t                         alu_left_o,
    output calc_pkg::num_t                         alu_right_o,
    output calc_pkg::op_t                          alu_op_o,
    output logic                                   alu_in_valid_o,
    input  logic                                   alu_in_ready_i,
    input  calc_pkg::num_t                         alu_result_i,
    input  logic                                   alu_out_valid_i,
    output logic                                   alu_out_ready_o,
    output logic           [GW-1:0]                grant_o,
    output logic                                   busy_o
);
    import calc_pkg::*;

    typedef struct packed {
        num_t left;
        num_t right;
        op_t  op;
    } alu_req_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RESULT, S_DELIVER} state_t;

    state_t         state_q, state_d;
    alu_req_t       cap_q;
    num_t           result_q;
    logic [GW-1:0]  grant_q, last_q;
    logic [GW-1:0]  winner;
    logic           found;
    logic           accept;
    int             idx;

    // Round-robin scan starting just after the last grant, wrapping modulo
    // NumRequesters (which need not be a power of two).
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NumRequesters; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NumRequesters) idx = idx - NumRequesters;
            if (!found && req_in_valid_i[idx[GW-1:0]]) begin
                found  = 1'b1;
                winner = idx[GW-1:0];
            end
        end
    end

    assign accept = (state_q == S_IDLE) && found;

    for (genvar g = 0; g < NumRequesters; g++) begin : g_lane
        assign req_in_ready_o[g]  = accept && (winner == GW'(g));
        assign req_out_valid_o[g] = (state_q == S_DELIVER) && (grant_q == GW'(g));
    end

    always_comb begin
        state_d         = state_q;
        alu_in_valid_o  = 1'b0;
        alu_out_ready_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (found) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                alu_in_valid_o = 1'b1;
                if (alu_in_ready_i) state_d = S_WAIT_RESULT;
            end
            S_WAIT_RESULT: begin
                alu_out_ready_o = 1'b1;
                if (alu_out_valid_i) state_d = S_DELIVER;
            end
            S_DELIVER: begin
                // Only the granted requester's ready can retire the result.
                if (req_out_ready_i[grant_q]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cap_q    <= '{left: '0, right: '0, op: OP_ADD};
            result_q <= '0;
            grant_q  <= '0;
            // Last grant starts at the top index so requester 0 wins first.
            last_q   <= GW'(NumRequesters - 1);
        end else begin
            state_q <= state_d;
            if (accept) begin
                cap_q   <= '{left: req_left_i[winner], right: req_right_i[winner],
                             op: req_op_i[winner]};
                grant_q <= winner;
                last_q  <= winner;
            end
            if (state_q == S_WAIT_RESULT && alu_out_valid_i) result_q <= alu_result_i;
        end
    end

    assign alu_left_o   = cap_q.left;
    assign alu_right_o  = cap_q.right;
    assign alu_op_o     = cap_q.op;
    assign req_result_o = result_q;
    assign grant_o      = grant_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    import calc_pkg::*;

    localparam int N  = 3;
    localparam int GW = $clog2(N);

    logic             clk = 1'b0;
    logic             rst_i;
    num_t  [N-1:0]    req_left, req_right;
    op_t   [N-1:0]    req_op;
    logic  [N-1:0]    req_in_valid, req_in_ready;
    num_t             req_result;
    logic  [N-1:0]    req_out_valid, req_out_ready;
    num_t             alu_left, alu_right, alu_result;
    op_t              alu_op;
    logic             alu_in_valid, alu_in_ready, alu_out_valid, alu_out_ready;
    logic  [GW-1:0]   grant;
    logic             busy;

    int checks = 0;
    int passes = 0;
    int model_last;

    always #5 clk = ~clk;

    alu_arbiter #(.NumRequesters(N)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_left_i(req_left), .req_right_i(req_right), .req_op_i(req_op),
        .req_in_valid_i(req_in_valid), .req_in_ready_o(req_in_ready),
        .req_result_o(req_result), .req_out_valid_o(req_out_valid),
        .req_out_ready_i(req_out_ready),
        .alu_left_o(alu_left), .alu_right_o(alu_right), .alu_op_o(alu_op),
        .alu_in_valid_o(alu_in_valid), .alu_in_ready_i(alu_in_ready),
        .alu_result_i(alu_result), .alu_out_valid_i(alu_out_valid),
        .alu_out_ready_o(alu_out_ready),
        .grant_o(grant), .busy_o(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Stand-in arithmetic for the stub ALU's answer.
    function automatic num_t ref_alu(num_t l, num_t r, op_t op);
        case (op)
            OP_ADD:  return l + r;
            OP_SUB:  return l - r;
            OP_MUL:  return l * r;
            default: return (r == 0) ? 16'hFFFF : l / r;
        endcase
    endfunction

    // One transaction (or an idle cycle if nobody is valid), wait states given
    // per handshake. Entered at posedge+1 with the DUT idle and inputs set.
    task automatic txn(input int win, input int wout, input int wdel,
                       input bit chg, input bit oth_hi);
        int w;
        num_t el, er, res;
        op_t eo;
        logic [N-1:0] oh;
        #1;
        w = -1;
        for (int k = 1; k <= N; k++)
            if (w < 0 && req_in_valid[(model_last + k) % N]) w = (model_last + k) % N;
        if (w < 0) begin
            chk("idle_rdy", req_in_ready, '0);
            tick();
            #1;
            chk("idle_busy", busy, 0);
            return;
        end
        oh = N'(1) << w;
        chk("acc_rdy", req_in_ready, oh);
        chk("acc_busy", busy, 0);
        el = req_left[w]; er = req_right[w]; eo = req_op[w];
        res = ref_alu(el, er, eo);
        model_last = w;
        tick();
        if (chg) begin
            req_left[w] = req_left[w] ^ 16'h000C;
            req_in_valid = '0;
        end
        for (int i = 0; i <= win; i++) begin
            alu_in_ready = (i == win);
            #1;
            chk("iss_valid", alu_in_valid, 1);
            chk("iss_rdy0", req_in_ready, '0);
            chk("iss_left", alu_left, el);
            chk("iss_right", alu_right, er);
            chk("iss_op", alu_op, eo);
            chk("iss_grant", grant, w);
            chk("iss_busy", busy, 1);
            tick();
        end
        alu_in_ready = 1'b0;
        for (int i = 0; i <= wout; i++) begin
            alu_out_valid = (i == wout);
            alu_result = (i == wout) ? res : num_t'($urandom);
            #1;
            chk("wait_ordy", alu_out_ready, 1);
            chk("wait_ivld", alu_in_valid, 0);
            chk("wait_ovld", req_out_valid, '0);
            tick();
        end
        alu_out_valid = 1'b0;
        for (int i = 0; i <= wdel; i++) begin
            req_out_ready = oth_hi ? ~oh : (N'($urandom) & ~oh);
            if (i == wdel) req_out_ready = req_out_ready | oh;
            #1;
            chk("del_ovld", req_out_valid, oh);
            chk("del_res", req_result, res);
            chk("del_ordy", alu_out_ready, 0);
            tick();
        end
        req_out_ready = '0;
        #1;
        chk("end_busy", busy, 0);
        chk("end_res", req_result, res);
    endtask

    initial begin
        rst_i = 1'b1;
        req_left = '0; req_right = '0; req_op = {N{OP_ADD}};
        req_in_valid = '0; req_out_ready = '0;
        alu_in_ready = 1'b0; alu_out_valid = 1'b0; alu_result = '0;
        model_last = N - 1;
        tick(); tick();
        chk("rst_rdy", req_in_ready, '0);
        chk("rst_ovld", req_out_valid, '0);
        chk("rst_ivld", alu_in_valid, 0);
        chk("rst_ordy", alu_out_ready, 0);
        chk("rst_left", alu_left, 0);
        chk("rst_right", alu_right, 0);
        chk("rst_op", alu_op, OP_ADD);
        chk("rst_res", req_result, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        rst_i = 1'b0;

        // Contention: req0 and req1 held valid, grants alternate 0,1,0,1.
        req_in_valid = 3'b011;
        for (int t = 0; t < 4; t++) begin
            req_left[0] = num_t'(10 + t); req_right[0] = 16'd1;
            req_left[1] = num_t'(20 + t); req_right[1] = 16'd2;
            txn(0, 0, 0, 0, 0);
            chk("cont_grant", grant, (t % 2));
        end

        // Single request 3+4 with zero waits.
        req_in_valid = 3'b001;
        req_left[0] = 16'd3; req_right[0] = 16'd4; req_op[0] = OP_ADD;
        txn(0, 0, 0, 0, 0);
        chk("single_res", req_result, 16'd7);

        // Wait states 3 / 5 / 2.
        req_in_valid = 3'b100;
        req_left[2] = 16'd100; req_right[2] = 16'd7; req_op[2] = OP_SUB;
        txn(3, 5, 2, 0, 0);

        // Operand capture: req1 changes left 5 -> 9 after acceptance.
        req_in_valid = 3'b010;
        req_left[1] = 16'd5; req_right[1] = 16'd6; req_op[1] = OP_MUL;
        txn(1, 1, 1, 1, 0);

        // Ignored ready: other requesters hold ready high during req1's delivery.
        req_in_valid = 3'b010;
        req_left[1] = 16'd50; req_right[1] = 16'd5; req_op[1] = OP_DIV;
        txn(0, 0, 3, 0, 1);

        // Reset while waiting on the ALU result.
        req_in_valid = 3'b010;
        req_left[1] = 16'h1234;
        #1;
        chk("rw_acc", req_in_ready, 3'b010);
        tick();
        req_in_valid = '0;
        alu_in_ready = 1'b1;
        #1;
        chk("rw_iss", alu_in_valid, 1);
        tick();
        alu_in_ready = 1'b0;
        #1;
        chk("rw_wait", alu_out_ready, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        alu_out_valid = 1'b1;
        alu_result = 16'hBEEF;
        #1;
        chk("rw_ivld", alu_in_valid, 0);
        chk("rw_ordy", alu_out_ready, 0);
        chk("rw_ovld", req_out_valid, '0);
        chk("rw_rdy", req_in_ready, '0);
        chk("rw_left", alu_left, 0);
        chk("rw_op", alu_op, OP_ADD);
        chk("rw_grant", grant, 0);
        chk("rw_busy", busy, 0);
        tick();
        alu_out_valid = 1'b0;
        #1;
        chk("rw_late_busy", busy, 0);
        chk("rw_late_res", req_result, 0);
        model_last = N - 1;
        req_in_valid = 3'b011;
        txn(0, 0, 0, 0, 0);
        chk("rw_next_grant", grant, 0);

        // Randomized traffic against the transaction-level model.
        for (int t = 0; t < 40; t++) begin
            req_in_valid = N'($urandom_range(0, (1 << N) - 1));
            for (int j = 0; j < N; j++) begin
                req_left[j]  = num_t'($urandom);
                req_right[j] = num_t'($urandom);
                req_op[j]    = op_t'($urandom_range(0, 3));
            end
            txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
